// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the 3-stage pipeline sequencing controller.
// State encodings, state width and counter defaults used by all pipe_ctrl files.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    localparam int unsigned BOOT_CYCLES_DFLT = 2;
    localparam int unsigned KILL_CYCLES_DFLT = 2;
    localparam int unsigned CNT_W_DFLT       = 32;

    // Widths sized for the legal ranges: boot 1..15, kill 1..3.
    localparam int unsigned BOOT_CNT_W = 4;
    localparam int unsigned KILL_CNT_W = 2;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake/control bundle between pipe_ctrl and the pipeline datapath.
// master = the controller, slave = the datapath it sequences.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic             valid_X;
    logic             br_taken_X;
    logic             dmem_busy;
    logic             cnt_clr;
    logic             pc_hold;
    logic             pc_redirect;
    logic             stall_ID;
    logic             stall_X;
    logic             stall_WB;
    logic             flush_ID;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  valid_X, br_taken_X, dmem_busy, cnt_clr,
        output pc_hold, pc_redirect, stall_ID, stall_X, stall_WB, flush_ID,
        output cycle_cnt, instr_cnt
    );

    modport slave (
        output valid_X, br_taken_X, dmem_busy, cnt_clr,
        input  pc_hold, pc_redirect, stall_ID, stall_X, stall_WB, flush_ID,
        input  cycle_cnt, instr_cnt
    );

endinterface

// File: rtl/perf_counter.sv
// Wrapping performance counter with synchronous clear and active-low sync reset.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the IF/ID, X, WB pipeline: boot window, branch kill
// window, data-memory wait stalls, and the cycle/retired-instruction counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = BOOT_CYCLES_DFLT,
    parameter int unsigned KILL_CYCLES = KILL_CYCLES_DFLT,
    parameter int unsigned CNT_W       = CNT_W_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);

    localparam logic [BOOT_CNT_W-1:0] BOOT_INIT = BOOT_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [KILL_CNT_W-1:0] KILL_INIT =
        (KILL_CYCLES > 1) ? KILL_CNT_W'(KILL_CYCLES - 2) : '0;

    state_e                state_q, state_d;
    logic [BOOT_CNT_W-1:0] boot_q, boot_d;
    logic [KILL_CNT_W-1:0] kill_q, kill_d;

    logic pc_hold, pc_redirect, stall_all, flush_id;
    logic mem_stall, take_br;

    assign mem_stall = bus.valid_X & bus.dmem_busy;
    assign take_br   = bus.valid_X & bus.br_taken_X;

    always_comb begin
        state_d     = state_q;
        boot_d      = boot_q;
        kill_d      = kill_q;
        pc_hold     = 1'b0;
        pc_redirect = 1'b0;
        stall_all   = 1'b0;
        flush_id    = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                pc_hold  = 1'b1;
                flush_id = 1'b1;
                if (boot_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q - 1'b1;
                end
            end
            // MEM_WAIT falls through to RUN evaluation on the release cycle.
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_MEM_WAIT && bus.dmem_busy) || mem_stall) begin
                    pc_hold   = 1'b1;
                    stall_all = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (take_br) begin
                        pc_redirect = 1'b1;
                        flush_id    = 1'b1;
                        if (KILL_CYCLES > 1) begin
                            state_d = ST_REDIRECT;
                            kill_d  = KILL_INIT;
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                flush_id = 1'b1;
                if (kill_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    kill_d = kill_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Reset is sampled at the edge, but outputs already reflect it this cycle.
        if (!rst) begin
            pc_hold     = 1'b1;
            flush_id    = 1'b1;
            pc_redirect = 1'b0;
            stall_all   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            boot_q  <= BOOT_INIT;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            kill_q  <= kill_d;
        end
    end

    assign bus.pc_hold     = pc_hold;
    assign bus.pc_redirect = pc_redirect;
    assign bus.stall_ID    = stall_all;
    assign bus.stall_X     = stall_all;
    assign bus.stall_WB    = stall_all;
    assign bus.flush_ID    = flush_id;

    logic cyc_en, ins_en;

    assign cyc_en = (state_q != ST_BOOT);
    assign ins_en = (state_q != ST_BOOT) & bus.valid_X & ~stall_all;

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cyc_en),
        .clr (bus.cnt_clr),
        .cnt (bus.cycle_cnt)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .en  (ins_en),
        .clr (bus.cnt_clr),
        .cnt (bus.instr_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic against a cycle-level
// model that tracks remaining boot/kill cycles and an outstanding-wait flag.
module tb_pipe_ctrl;

    localparam int unsigned BOOT  = 2;
    localparam int unsigned KILL  = 2;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .BOOT_CYCLES (BOOT),
        .KILL_CYCLES (KILL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int              boot_left = BOOT;
    int              kill_left = 0;
    bit              waiting   = 1'b0;
    logic [CNT_W-1:0] exp_cyc  = '0;
    logic [CNT_W-1:0] exp_ins  = '0;

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic d,
                        input logic c);
        logic e_stall, e_red, e_hold, e_flush;
        bit   quiet;
        @(negedge clk);
        rst            = r;
        bus.valid_X    = v;
        bus.br_taken_X = b;
        bus.dmem_busy  = d;
        bus.cnt_clr    = c;
        #1;
        quiet   = r && boot_left == 0 && kill_left == 0;
        e_stall = quiet && ((waiting && d) || (v && d));
        e_red   = quiet && !e_stall && v && b;
        e_hold  = !r || boot_left > 0 || e_stall;
        e_flush = !r || boot_left > 0 || kill_left > 0 || e_red;
        if (r && kill_left > 0) begin
            checks++;
            assert (bus.valid_X == 1'b0) else begin
                failures++;
                $error("FAIL valid_in_redirect observed=%0b expected=0", bus.valid_X);
            end
        end
        chk("pc_hold", CNT_W'(bus.pc_hold), CNT_W'(e_hold));
        chk("pc_redirect", CNT_W'(bus.pc_redirect), CNT_W'(e_red));
        chk("stall_ID", CNT_W'(bus.stall_ID), CNT_W'(e_stall));
        chk("stall_X", CNT_W'(bus.stall_X), CNT_W'(e_stall));
        chk("stall_WB", CNT_W'(bus.stall_WB), CNT_W'(e_stall));
        chk("flush_ID", CNT_W'(bus.flush_ID), CNT_W'(e_flush));
        chk("cycle_cnt", bus.cycle_cnt, exp_cyc);
        chk("instr_cnt", bus.instr_cnt, exp_ins);
        @(posedge clk);
        if (!r) begin
            boot_left = BOOT;
            kill_left = 0;
            waiting   = 1'b0;
            exp_cyc   = '0;
            exp_ins   = '0;
        end else begin
            if (c) begin
                exp_cyc = '0;
                exp_ins = '0;
            end else if (boot_left == 0) begin
                exp_cyc = exp_cyc + 1'b1;
                if (v && !e_stall) exp_ins = exp_ins + 1'b1;
            end
            if (boot_left > 0) begin
                boot_left--;
            end else if (kill_left > 0) begin
                kill_left--;
            end else if (e_stall) begin
                waiting = 1'b1;
            end else begin
                waiting = 1'b0;
                if (v && b) kill_left = KILL - 1;
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.valid_X    = 1'b0;
        bus.br_taken_X = 1'b0;
        bus.dmem_busy  = 1'b0;
        bus.cnt_clr    = 1'b0;

        // Reset, then boot window and first RUN cycles.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);

        // Taken branch and its kill window.
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Three-cycle data-memory wait, then release retires.
        repeat (3) step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Branch seen while busy only redirects on the release cycle.
        repeat (2) step(1, 1, 1, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // instr_cnt wrap.
        #2;
        force dut.u_instr_cnt.cnt_q = '1;
        #1;
        release dut.u_instr_cnt.cnt_q;
        exp_ins = '1;
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Clear together with a retire.
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        // Reset during MEM_WAIT, then full boot again.
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, v, b, d, c;
            r = ($urandom_range(0, 99) != 0);
            v = (kill_left > 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 3) == 0);
            d = 1'($urandom_range(0, 2) == 0);
            c = 1'($urandom_range(0, 24) == 0);
            step(r, v, b, d, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencing controller for the 3-stage (IF/ID, X, WB) RISC-V pipeline.
- Generates PC hold/redirect, per-stage stall and flush (bubble-insert) controls.
- Sequences the post-reset boot window, taken-branch/jump kill window and multi-cycle data-memory waits.
- Owns the cycle and retired-instruction performance counters read through the CSR/MMIO path.
- Operand forwarding is outside this block; this block only guarantees that forwarding sources stay coherent across stalls.

Parameters:
- BOOT_CYCLES, 2, cycles after reset release during which PC is held and all stages are flushed (primes synchronous IMEM/BIOS reads); legal range 1..15.
- KILL_CYCLES, 2, wrong-path bubbles inserted after a taken control transfer resolved in X; legal range 1..3.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- valid_X  in  1  X stage holds a real (non-bubble) instruction.
- br_taken_X  in  1  X-stage branch taken, or JAL/JALR; qualified by valid_X.
- dmem_busy  in  1  multi-cycle data access of the X instruction still pending.
- cnt_clr  in  1  synchronous clear of both counters (MMIO write strobe).
- pc_hold  out  1  PC register keeps its value.
- pc_redirect  out  1  PC loads the X-stage target this edge.
- stall_ID  out  1  IF/ID→X pipeline register holds.
- stall_X  out  1  X→WB pipeline register holds.
- stall_WB  out  1  WB register holds.
- flush_ID  out  1  IF/ID→X register loads a bubble.
- cycle_cnt  out  CNT_W  cycles since reset/clear, excluding BOOT.
- instr_cnt  out  CNT_W  instructions retired from X into WB.

Behaviour:
- All outputs are combinational from state and inputs; counters are registered.
- While rst=0 (sampled at the edge): state←BOOT, boot counter←BOOT_CYCLES-1, kill counter←0, counters←0.
- Outputs during reset: pc_hold=1, flush_ID=1, pc_redirect=0, all stalls=0.
- Reset asserted mid-operation (MEM_WAIT, REDIRECT) aborts the operation identically to power-up.
- States: BOOT, RUN, MEM_WAIT, REDIRECT; encodings live in the shared header.
- BOOT:
  - pc_hold=1, flush_ID=1, inputs ignored.
  - Decrement each cycle; →RUN after exactly BOOT_CYCLES cycles.
- RUN:
  - If valid_X & dmem_busy: stall_ID=stall_X=stall_WB=pc_hold=1, redirect suppressed, →MEM_WAIT.
  - Else if valid_X & br_taken_X: pc_redirect=1, flush_ID=1.
    - KILL_CYCLES=1: stay in RUN.
    - Otherwise →REDIRECT with kill counter←KILL_CYCLES-2.
- MEM_WAIT:
  - All stages plus PC held (WB held too, so the WB forwarding source and a repeated idempotent RF write stay valid); no bubbles.
  - Stay while dmem_busy. On the first cycle dmem_busy=0, re-evaluate exactly as RUN, same cycle (branch/stall priority identical).
- REDIRECT:
  - flush_ID=1, no stalls.
  - Decrement; →RUN when the counter reaches 0.
  - dmem_busy and br_taken_X are ignored because X holds a bubble; a bench assertion flags valid_X=1 here.
- Priority: reset > dmem_busy stall > redirect.
- cycle_cnt:
  - +1 every cycle with state≠BOOT, including stalled cycles.
- instr_cnt:
  - +1 when valid_X & ~stall_X.
  - A taken branch counts once; wrong-path bubbles never count.
- cnt_clr dominates increment: the next value is 0.
- Counters wrap modulo 2^CNT_W silently.

Decomposition:
- Shared header pipe_ctrl_defs.vh: state encodings (ST_BOOT, ST_RUN, ST_MEM_WAIT, ST_REDIRECT), state width, counter defaults.
- One sub-module perf_counter (CNT_W, en, clr, synchronous active-low rst), instantiated twice.

Test Plan:
- BOOT_CYCLES=2: release rst at cycle 0 → pc_hold=flush_ID=1 in cycles 0–1, 0 in cycle 2; cycle_cnt=1 at cycle 3.
- RUN, valid_X=1, br_taken_X=1 for one cycle, KILL_CYCLES=2 → pc_redirect=1 that cycle only; flush_ID=1 for 2 consecutive cycles; instr_cnt +1.
- valid_X=1, dmem_busy=1 for 3 cycles, with br_taken_X=0 → all stalls and pc_hold=1 for 3 cycles; instr_cnt unchanged during them, +1 on release; cycle_cnt +3.
- Redirect-during-stall: dmem_busy=1 and br_taken_X=1 on the same cycle, then busy drops → pc_redirect=0 while busy; pc_redirect=1 exactly on the release cycle.
- Counter edges:
  - Preload instr_cnt to 0xFFFFFFFF via force, retire one → 0x0.
  - cnt_clr together with a retire → both counters 0.
- rst=0 asserted in MEM_WAIT, then released → stalls drop, BOOT sequence repeats, counters 0.
